// File: rtl/alu_div32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state codes,
// default operand width and the iteration-counter width helper.
package alu_div32_seq_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/alu_div32_seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, then trial-subtract the divisor using an inverter and a carry-in ripple adder.
module alu_div32_seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    // The stored remainder is always below the divisor, so it fits in WIDTH bits;
    // only the shifted value needs the extra top bit.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] d_inv;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] carry;

    assign shifted = {r, q_msb};
    assign d_inv   = ~{1'b0, d};

    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = shifted[i] ^ d_inv[i] ^ carry[i];
            if (i < WIDTH) begin
                carry[i+1] = (shifted[i] & d_inv[i]) | (carry[i] & (shifted[i] ^ d_inv[i]));
            end
        end
    end

    // A clear top bit means the subtraction did not borrow.
    assign q_bit  = ~diff[WIDTH];
    assign r_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_div32_seq.sv
// Multi-cycle unsigned restoring divider driven by a start/done handshake;
// one quotient bit per clock, divide-by-zero short-circuits to DONE.
module alu_div32_seq
    import alu_div32_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;

    alu_div32_seq_div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[WIDTH-1]),
        .d      (d_reg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DIV_IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        q_reg <= dividend;
                        r_reg <= '0;
                        d_reg <= divisor;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DIV_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            state       <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    q_reg <= {q_reg[WIDTH-2:0], q_bit};
                    r_reg <= r_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        quotient  <= {q_reg[WIDTH-2:0], q_bit};
                        remainder <= r_next;
                        done      <= 1'b1;
                        state     <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div32_seq.sv
// Self-checking bench for alu_div32_seq: a transaction-level model (native / and %,
// fixed latency) is compared against every DUT output on every cycle.
module tb_alu_div32_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_div32_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Model: an accepted request keeps the unit busy for a fixed number of edges,
    // then shows the arithmetic result for one cycle and holds it.
    bit               m_busy = 1'b0;
    bit               m_done = 1'b0;
    bit               m_dbz = 1'b0;
    logic [WIDTH-1:0] m_q = '0;
    logic [WIDTH-1:0] m_r = '0;
    logic [WIDTH-1:0] p_q = '0;
    logic [WIDTH-1:0] p_r = '0;
    int               m_cd = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dbz  = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_cd   = 0;
        end else if (m_busy) begin
            if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else begin
                m_cd--;
                if (m_cd == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                end
            end
        end else if (start) begin
            m_busy = 1'b1;
            if (divisor == 0) begin
                m_q    = '1;
                m_r    = dividend;
                m_dbz  = 1'b1;
                m_done = 1'b1;
            end else begin
                p_q   = dividend / divisor;
                p_r   = dividend % divisor;
                m_dbz = 1'b0;
                m_cd  = WIDTH;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("busy", {31'b0, busy}, {31'b0, m_busy});
        checkOutput("done", {31'b0, done}, {31'b0, m_done});
        checkOutput("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
        checkOutput("quotient", quotient, m_q);
        checkOutput("remainder", remainder, m_r);
    end

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("launch_idle", {31'b0, busy}, 32'd0);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 1;
        while (!done && lat < 60) begin
            @(posedge clk);
            #2;
            lat++;
        end
        checkOutput("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output int lat);
        launch(a, b);
        waitDone(lat);
    endtask

    function automatic logic [WIDTH-1:0] randDivisor();
        case ($urandom_range(0, 9))
            0:       return '0;
            1, 2:    return WIDTH'($urandom_range(1, 15));
            3:       return '1;
            4, 5:    return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int pulses;
        int n;
        bit prev;
        bit acc;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_dbz", {31'b0, div_by_zero}, 32'd0);
        checkOutput("reset_quotient", quotient, 32'd0);
        checkOutput("reset_remainder", remainder, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        $display("[TB] 100 / 7");
        applyStimulus(32'd100, 32'd7, lat);
        checkOutput("t1_latency", lat, 32'd33);
        checkOutput("t1_quotient", quotient, 32'd14);
        checkOutput("t1_remainder", remainder, 32'd2);
        checkOutput("t1_dbz", {31'b0, div_by_zero}, 32'd0);
        checkOutput("t1_model_q", m_q, 32'd14);
        checkOutput("t1_model_r", m_r, 32'd2);
        @(posedge clk);
        #2;
        checkOutput("t1_done_drops", {31'b0, done}, 32'd0);
        checkOutput("t1_quotient_held", quotient, 32'd14);

        $display("[TB] all-ones operands");
        applyStimulus(32'hFFFF_FFFF, 32'd1, lat);
        checkOutput("t2a_quotient", quotient, 32'hFFFF_FFFF);
        checkOutput("t2a_remainder", remainder, 32'd0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checkOutput("t2b_quotient", quotient, 32'd1);
        checkOutput("t2b_remainder", remainder, 32'd0);

        $display("[TB] divide by zero");
        applyStimulus(32'd5, 32'd0, lat);
        checkOutput("t3_latency", lat, 32'd1);
        checkOutput("t3_dbz", {31'b0, div_by_zero}, 32'd1);
        checkOutput("t3_quotient", quotient, 32'hFFFF_FFFF);
        checkOutput("t3_remainder", remainder, 32'd5);
        checkOutput("t3_model_r", m_r, 32'd5);

        $display("[TB] start ignored while running");
        launch(32'd3, 32'd10);
        repeat (5) @(posedge clk);
        #2;
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clk);
        #2;
        start = 1'b0;
        waitDone(lat);
        checkOutput("t4_quotient", quotient, 32'd0);
        checkOutput("t4_remainder", remainder, 32'd3);
        checkOutput("t4_dbz_cleared", {31'b0, div_by_zero}, 32'd0);

        $display("[TB] reset mid-operation");
        launch(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t5_busy", {31'b0, busy}, 32'd0);
        checkOutput("t5_done", {31'b0, done}, 32'd0);
        checkOutput("t5_quotient", quotient, 32'd0);
        checkOutput("t5_remainder", remainder, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #2;
            if (done) pulses++;
        end
        checkOutput("t5_no_done", pulses, 32'd0);
        applyStimulus(32'd1000, 32'd3, lat);
        checkOutput("t5_quotient_rerun", quotient, 32'd333);
        checkOutput("t5_remainder_rerun", remainder, 32'd1);
        checkOutput("t5_model_q", m_q, 32'd333);

        $display("[TB] back-to-back random operations");
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            dividend = $urandom;
            divisor  = randDivisor();
            n   = 0;
            acc = 1'b0;
            while (!acc && n < 80) begin
                prev = busy;
                @(posedge clk);
                #2;
                acc = !prev && busy;
                n++;
            end
            checkOutput("t6_accept", {31'b0, acc}, 32'd1);
        end
        start = 1'b0;
        waitDone(lat);
        repeat (3) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
